// File: rtl/jtopl_timer_pair.sv
// OPL-style timer pair: a shared sample prescaler drives timer A (every 4 samples) and timer B (every 16).
// Optional macro JTOPL_TIMER_IRQ_EN enables the registered active-low interrupt output.
module jtopl_timer_pair (
    input  logic       clk,
    input  logic       rst,
    input  logic       cenop,
    input  logic       zero,
    input  logic [7:0] value_A,
    input  logic [7:0] value_B,
    input  logic       load_A,
    input  logic       load_B,
    input  logic       flagen_A,
    input  logic       flagen_B,
    input  logic       clr_flag_A,
    input  logic       clr_flag_B,
    output logic       flag_A,
    output logic       flag_B,
    output logic       overflow_A,
    output logic       irq_n
);

    logic [3:0] presc_q;
    logic       load_a_l_q, load_b_l_q;
    logic [7:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic       ovf_a_evt, ovf_b_evt;
    logic       flag_a_q, flag_a_d, flag_b_q, flag_b_d;
    logic       ovf_a_q;
    logic       tick_a, tick_b;

    // Returns {overflow_event, next_count}; a fresh load edge beats a coincident tick.
    function automatic logic [8:0] timer_next(input logic [7:0] cnt, input logic [7:0] value,
                                              input logic load, input logic load_l,
                                              input logic tick);
        logic [8:0] r;
        r = {1'b0, cnt};
        if (load && !load_l) begin
            r = {1'b0, value};
        end else if (load && tick) begin
            if (cnt == 8'hFF) r = {1'b1, value};
            else              r = {1'b0, cnt + 8'd1};
        end
        return r;
    endfunction

    // Setting by overflow takes priority over a simultaneous clear request.
    function automatic logic flag_next(input logic flag, input logic ovf,
                                       input logic flagen, input logic clr);
        logic r;
        r = flag;
        if (ovf && flagen) r = 1'b1;
        else if (clr)      r = 1'b0;
        return r;
    endfunction

    assign tick_a = cenop & zero & (presc_q[1:0] == 2'd3);
    assign tick_b = cenop & zero & (presc_q == 4'd15);

    always_comb begin
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        ovf_a_evt = 1'b0;
        ovf_b_evt = 1'b0;
        flag_a_d  = flag_a_q;
        flag_b_d  = flag_b_q;
        if (cenop) begin
            {ovf_a_evt, cnt_a_d} = timer_next(cnt_a_q, value_A, load_A, load_a_l_q, tick_a);
            {ovf_b_evt, cnt_b_d} = timer_next(cnt_b_q, value_B, load_B, load_b_l_q, tick_b);
            flag_a_d = flag_next(flag_a_q, ovf_a_evt, flagen_A, clr_flag_A);
            flag_b_d = flag_next(flag_b_q, ovf_b_evt, flagen_B, clr_flag_B);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= 4'd0;
            load_a_l_q <= 1'b0;
            load_b_l_q <= 1'b0;
            cnt_a_q    <= 8'd0;
            cnt_b_q    <= 8'd0;
            flag_a_q   <= 1'b0;
            flag_b_q   <= 1'b0;
            ovf_a_q    <= 1'b0;
        end else begin
            if (cenop && zero) presc_q <= presc_q + 4'd1;
            if (cenop) begin
                load_a_l_q <= load_A;
                load_b_l_q <= load_B;
                ovf_a_q    <= ovf_a_evt;
            end
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            flag_a_q <= flag_a_d;
            flag_b_q <= flag_b_d;
        end
    end

    assign flag_A     = flag_a_q;
    assign flag_B     = flag_b_q;
    assign overflow_A = ovf_a_q;

`ifdef JTOPL_TIMER_IRQ_EN
    logic irq_n_q;

    always_ff @(posedge clk) begin
        if (rst) irq_n_q <= 1'b1;
        else     irq_n_q <= ~(flag_a_d | flag_b_d);
    end

    assign irq_n = irq_n_q;
`else
    assign irq_n = 1'b1;
`endif

endmodule

// File: tb/tb_jtopl_timer_pair.sv
// Directed bench for jtopl_timer_pair: cenop every 4 clk, zero on every 18th cenop.
module tb_jtopl_timer_pair;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cenop = 1'b0;
    logic       zero = 1'b0;
    logic [7:0] value_A = 8'd0;
    logic [7:0] value_B = 8'd0;
    logic       load_A = 1'b0;
    logic       load_B = 1'b0;
    logic       flagen_A = 1'b0;
    logic       flagen_B = 1'b0;
    logic       clr_flag_A = 1'b0;
    logic       clr_flag_B = 1'b0;
    logic       flag_A, flag_B, overflow_A, irq_n;

    int tests = 0;
    int fails = 0;

`ifdef JTOPL_TIMER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    jtopl_timer_pair dut (
        .clk        (clk),
        .rst        (rst),
        .cenop      (cenop),
        .zero       (zero),
        .value_A    (value_A),
        .value_B    (value_B),
        .load_A     (load_A),
        .load_B     (load_B),
        .flagen_A   (flagen_A),
        .flagen_B   (flagen_B),
        .clr_flag_A (clr_flag_A),
        .clr_flag_B (clr_flag_B),
        .flag_A     (flag_A),
        .flag_B     (flag_B),
        .overflow_A (overflow_A),
        .irq_n      (irq_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cenop(input logic z);
        cenop = 1'b0;
        zero  = 1'b0;
        repeat (3) step();
        cenop = 1'b1;
        zero  = z;
        step();
        cenop = 1'b0;
        zero  = 1'b0;
    endtask

    // One sample period; the zero cenop comes last so outputs can be checked right after.
    task automatic sample();
        repeat (17) do_cenop(1'b0);
        do_cenop(1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        // Timer A reload FE: overflow on the 2nd tick, i.e. sample 8, then every 8 samples
        value_A = 8'hFE; flagen_A = 1'b1;
        do_reset();
        chk("rst_flagA", {7'd0, flag_A}, 8'd0);
        chk("rst_flagB", {7'd0, flag_B}, 8'd0);
        chk("rst_ovfA", {7'd0, overflow_A}, 8'd0);
        chk("rst_irq", {7'd0, irq_n}, 8'd1);
        load_A = 1'b1;
        repeat (7) sample();
        chk("a_s7_ovf", {7'd0, overflow_A}, 8'd0);
        chk("a_s7_flag", {7'd0, flag_A}, 8'd0);
        sample();
        chk("a_s8_ovf", {7'd0, overflow_A}, 8'd1);
        chk("a_s8_flag", {7'd0, flag_A}, 8'd1);
        chk("a_s8_irq", {7'd0, irq_n}, {7'd0, ~IRQ_ON});
        do_cenop(1'b0);
        chk("a_pulse_end", {7'd0, overflow_A}, 8'd0);
        repeat (7) sample();
        chk("a_s15_ovf", {7'd0, overflow_A}, 8'd0);
        sample();
        chk("a_s16_ovf", {7'd0, overflow_A}, 8'd1);

        // Clear request held across non-cenop clocks takes effect only on cenop
        clr_flag_A = 1'b1;
        repeat (3) step();
        chk("clr_wait", {7'd0, flag_A}, 8'd1);
        cenop = 1'b1;
        step();
        cenop = 1'b0;
        chk("clr_done", {7'd0, flag_A}, 8'd0);
        chk("clr_irq", {7'd0, irq_n}, 8'd1);
        clr_flag_A = 1'b0;
        repeat (7) sample();
        clr_flag_A = 1'b1;
        sample();
        clr_flag_A = 1'b0;
        chk("set_wins_flag", {7'd0, flag_A}, 8'd1);
        chk("set_wins_ovf", {7'd0, overflow_A}, 8'd1);

        // Reload FF with flagen off: overflow every tick, flag never set
        value_A = 8'hFF; flagen_A = 1'b0; load_A = 1'b1;
        do_reset();
        repeat (3) sample();
        chk("ff_s3_ovf", {7'd0, overflow_A}, 8'd0);
        sample();
        chk("ff_s4_ovf", {7'd0, overflow_A}, 8'd1);
        chk("ff_s4_flag", {7'd0, flag_A}, 8'd0);
        do_cenop(1'b0);
        chk("ff_pulse_end", {7'd0, overflow_A}, 8'd0);
        repeat (4) sample();
        chk("ff_s8_ovf", {7'd0, overflow_A}, 8'd1);
        chk("ff_s8_flag", {7'd0, flag_A}, 8'd0);

        // Stop at 80, hold while load is low, then reload 10; later value change waits for reload
        value_A = 8'h7E; flagen_A = 1'b1; load_A = 1'b1;
        do_reset();
        repeat (8) sample();
        chk("hold_cnt80", dut.cnt_a_q, 8'h80);
        load_A = 1'b0;
        repeat (4) sample();
        chk("hold_still80", dut.cnt_a_q, 8'h80);
        chk("hold_noflag", {7'd0, flag_A}, 8'd0);
        value_A = 8'h10; load_A = 1'b1;
        do_cenop(1'b0);
        chk("reload_10", dut.cnt_a_q, 8'h10);
        value_A = 8'h20;
        repeat (4) sample();
        chk("value_late", dut.cnt_a_q, 8'h11);

        // Reset lands on the zero cenop that would have overflowed FF
        value_A = 8'hFF; flagen_A = 1'b1; load_A = 1'b1;
        do_reset();
        repeat (3) sample();
        repeat (17) do_cenop(1'b0);
        repeat (3) step();
        rst = 1'b1; cenop = 1'b1; zero = 1'b1;
        step();
        rst = 1'b0; cenop = 1'b0; zero = 1'b0;
        chk("rstmid_ovf", {7'd0, overflow_A}, 8'd0);
        chk("rstmid_flag", {7'd0, flag_A}, 8'd0);
        chk("rstmid_irq", {7'd0, irq_n}, 8'd1);
        chk("rstmid_cnt", dut.cnt_a_q, 8'h00);
        do_cenop(1'b0);
        chk("rstmid_reload", dut.cnt_a_q, 8'hFF);
        chk("rstmid_ovf2", {7'd0, overflow_A}, 8'd0);

        // Timer B reload F0: 16 B ticks (256 samples) to first flag; timer A idle
        value_A = 8'h00; load_A = 1'b0; flagen_A = 1'b1;
        value_B = 8'hF0; load_B = 1'b1; flagen_B = 1'b1;
        do_reset();
        repeat (255) sample();
        chk("b_s255_flag", {7'd0, flag_B}, 8'd0);
        chk("b_idleA_ovf", {7'd0, overflow_A}, 8'd0);
        sample();
        chk("b_s256_flag", {7'd0, flag_B}, 8'd1);
        chk("b_s256_irq", {7'd0, irq_n}, {7'd0, ~IRQ_ON});
        chk("b_idleA_flag", {7'd0, flag_A}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
